// File: rtl/mdu_sequencer.sv
`timescale 1ns/1ps
// mdu_sequencer: iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// It claims R-type ops whose Funct7 selects the M extension, holds the pipeline with a
// combinational stall while it iterates one bit per cycle, and returns a registered
// Result together with a one-cycle done pulse.
module mdu_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [6:0] M_FUNCT7   = 7'b0000001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [1:0]            ALUOp,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]  MIN_INT  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Conditional two's-complement negate of a single-width value.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    logic [W-1:0] r;
    if (n) r = ~v + {{(W-1){1'b0}}, 1'b1};
    else   r = v;
    return r;
  endfunction

  // Conditional two's-complement negate of a double-width product.
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    logic [2*W-1:0] r;
    if (n) r = ~v + {{(2*W-1){1'b0}}, 1'b1};
    else   r = v;
    return r;
  endfunction

  // Sequencer state. acc_r holds {hi, lo}: product accumulator / multiplier for MUL,
  // {partial remainder, dividend-shifting-into-quotient} for DIV. op_r is the
  // multiplicand (MUL) or divisor (DIV), both as magnitudes.
  logic [1:0]     state_r;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] acc_r;
  logic [W-1:0]   op_r;
  logic [2:0]     f3_r;
  logic           neg_r;
  logic [W-1:0]   result_r;

  logic           m_op_s;
  logic           issue_s;
  logic           a_signed_s;
  logic           b_signed_s;
  logic           neg_a_s;
  logic           neg_b_s;
  logic [W-1:0]   abs_a_s;
  logic [W-1:0]   abs_b_s;
  logic           res_neg_s;
  logic           div_zero_s;
  logic           div_ovf_s;
  logic           special_s;
  logic [W-1:0]   special_val_s;

  logic [W:0]     mul_sum_s;
  logic [2*W-1:0] mul_next_s;
  logic [2*W-1:0] mul_prod_s;
  logic [W-1:0]   mul_res_s;
  logic [W:0]     div_shift_s;
  logic [W:0]     div_diff_s;
  logic [W-1:0]   div_rem_s;
  logic [W-1:0]   div_quo_s;
  logic [2*W-1:0] div_next_s;
  logic [W-1:0]   div_res_s;

  assign m_op_s  = req & (ALUOp == 2'b10) & (Funct7 == M_FUNCT7);
  assign issue_s = m_op_s & (state_r == S_IDLE) & ~flush;
  assign done    = (state_r == S_DONE);
  assign busy    = (state_r != S_IDLE);
  assign stall   = m_op_s & ~done;
  assign Result  = result_r;

  // Issue-time decode: operand signedness, magnitudes, result sign and the
  // division corner cases that finish without iterating.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (Funct3)
      3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    neg_a_s = a_signed_s & SrcA[W-1];
    neg_b_s = b_signed_s & SrcB[W-1];
    abs_a_s = neg_w(SrcA, neg_a_s);
    abs_b_s = neg_w(SrcB, neg_b_s);
    // Remainder follows the dividend sign; product and quotient use the sign product.
    if (Funct3[2] & Funct3[1]) res_neg_s = neg_a_s;
    else                       res_neg_s = neg_a_s ^ neg_b_s;
    div_zero_s = Funct3[2] & (SrcB == {W{1'b0}});
    div_ovf_s  = Funct3[2] & ~Funct3[0] & (SrcA == MIN_INT) & (SrcB == ALL_ONES);
    special_s  = div_zero_s | div_ovf_s;
    if (div_zero_s)     special_val_s = Funct3[1] ? SrcA : ALL_ONES;
    else if (div_ovf_s) special_val_s = Funct3[1] ? {W{1'b0}} : MIN_INT;
    else                special_val_s = {W{1'b0}};
  end

  // One iteration step of shift-add multiply and restoring divide, plus the
  // sign-corrected final result used on the step that enters DONE.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, op_r} : {(W+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[W-1:1]};
    mul_prod_s = neg_2w(mul_next_s, neg_r);
    if (f3_r[1:0] == 2'b00) mul_res_s = mul_prod_s[W-1:0];
    else                    mul_res_s = mul_prod_s[2*W-1:W];

    div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
    div_diff_s  = div_shift_s - {1'b0, op_r};
    // A borrow out of the guard bit means the divisor did not fit: restore.
    if (div_diff_s[W]) div_rem_s = div_shift_s[W-1:0];
    else               div_rem_s = div_diff_s[W-1:0];
    div_quo_s  = {acc_r[W-2:0], ~div_diff_s[W]};
    div_next_s = {div_rem_s, div_quo_s};
    if (f3_r[1]) div_res_s = neg_w(div_rem_s, neg_r);
    else         div_res_s = neg_w(div_quo_s, neg_r);
  end

  // Sequencing FSM and datapath registers; flush overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      op_r     <= {W{1'b0}};
      f3_r     <= 3'b000;
      neg_r    <= 1'b0;
      result_r <= {W{1'b0}};
    end else if (flush) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (issue_s) begin
            f3_r  <= Funct3;
            neg_r <= res_neg_s;
            cnt_r <= {CW{1'b0}};
            if (special_s) begin
              state_r  <= S_DONE;
              result_r <= special_val_s;
            end else if (Funct3[2]) begin
              state_r <= S_DIV;
              acc_r   <= {{W{1'b0}}, abs_a_s};
              op_r    <= abs_b_s;
            end else begin
              state_r <= S_MUL;
              acc_r   <= {{W{1'b0}}, abs_b_s};
              op_r    <= abs_a_s;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_r <= mul_next_s;
          if (cnt_r == LAST_CNT) begin
            state_r  <= S_DONE;
            result_r <= mul_res_s;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DIV: begin
          acc_r <= div_next_s;
          if (cnt_r == LAST_CNT) begin
            state_r  <= S_DONE;
            result_r <= div_res_s;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
`timescale 1ns/1ps
// tb_mdu_sequencer: randomized scoreboard bench. The driver issues M ops and pushes the
// arithmetic reference result and the expected done cycle; a monitor pops on every done.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [6:0]  Funct7 = 7'd0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic [2:0]  f3;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] last_result = 32'd0;

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
    .stall(stall), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: plain wide arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return 33;
  endfunction

  // Issue one M op just after a rising edge and hold it until done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   seen;
    req = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b;
    e.data = ref_model(f3, a, b);
    e.f3   = f3;
    e.cyc  = cyc + ref_latency(f3, a, b);
    sbq.push_back(e);
    last_result = e.data;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        check("stall_at_done", {31'b0, stall}, 32'd0);
        seen = 1'b1;
      end else begin
        check("stall_while_busy", {31'b0, stall}, 32'd1);
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: no done within 40 cycles, f3=%0d", f3);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Present a non-M request for two cycles; the unit must ignore it.
  task automatic non_m_check();
    int v;
    req = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      ALUOp  = 2'b10;
      Funct7 = 7'($urandom_range(2, 127));
    end else begin
      v = $urandom_range(0, 2);
      if (v == 2) v = 3;
      ALUOp  = 2'(v);
      Funct7 = 7'b0000001;
    end
    Funct3 = 3'($urandom_range(0, 7));
    SrcA   = $urandom;
    SrcB   = $urandom;
    repeat (2) begin
      @(negedge clk);
      check("non_m_stall", {31'b0, stall}, 32'd0);
      check("non_m_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no op pending", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check($sformatf("result_f3_%0d", mon_e.f3), Result, mon_e.data);
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          mode;

    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", Result, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, issued back to back.
    run_op(3'd0, 32'd7, 32'hFFFFFFFD);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF);

    // Flush at cycle 10 of a MUL: no done, Result untouched.
    req = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0;
    SrcA = 32'h1234_5678; SrcB = 32'h0000_0ABC;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result", Result, last_result);
    repeat (40) @(negedge clk);
    check("flush_result_later", Result, last_result);
    @(posedge clk); #1;
    run_op(3'd4, 32'hFFFF_0001, 32'd13);

    // Flush in the same cycle as a would-be issue: nothing starts.
    req = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd5;
    SrcA = 32'd50; SrcB = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    check("flush_issue_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset at cycle 5 of a DIV.
    req = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd4;
    SrcA = 32'd100; SrcB = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; req = 1'b0;
    #1;
    check("midop_reset_done", {31'b0, done}, 32'd0);
    check("midop_reset_busy", {31'b0, busy}, 32'd0);
    check("midop_reset_result", Result, 32'd0);
    check("midop_reset_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_result = 32'd0;
    @(posedge clk); #1;

    // Randomized ops with corner cases mixed in.
    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: begin a = -32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op(f3, a, b);
      if (i % 8 == 7) non_m_check();
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
